// File: rtl/iir_tdm_mc.sv
`default_nettype none
// ============================================================================
// iir_tdm_mc : CH-channel time-multiplexed order-N IIR, one serial MAC unit
// Rev 1.0
// ============================================================================
module iir_tdm_mc #(
    parameter  int N        = 4,
    parameter  int CH       = 4,
    parameter  int BITWIDTH = 32,
    parameter  int FAC      = 20,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW       = $clog2(2*N+1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_W-1:0]            in_ch,
    input  logic signed [BITWIDTH-1:0] x,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic signed [BITWIDTH-1:0] y,
    output logic                       out_sat,
    output logic                       err_ch,
    input  logic                       coef_we,
    input  logic [AW-1:0]              coef_addr,
    input  logic signed [BITWIDTH-1:0] coef_data,
    output logic                       busy
);

    localparam int NC    = 2*N + 1;
    localparam int PW    = 2*BITWIDTH;
    localparam int ACC_W = PW + AW;

    localparam logic [AW-1:0]              c_last_b = AW'(N);
    localparam logic [AW-1:0]              c_last   = AW'(NC-1);
    localparam logic [CH_W:0]              c_ch     = (CH_W+1)'(CH);
    localparam logic signed [BITWIDTH-1:0] c_one    = {{(BITWIDTH-1){1'b0}}, 1'b1} << FAC;
    localparam logic signed [ACC_W-1:0]    c_half   = {{(ACC_W-1){1'b0}}, 1'b1} << (FAC-1);
    localparam logic signed [ACC_W-1:0]    c_ymax   = {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]    c_ymin   = {{(ACC_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                       r_state;
    logic [AW-1:0]                r_cnt;
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [BITWIDTH-1:0]   r_x;
    logic [CH_W-1:0]              r_ch;
    logic signed [BITWIDTH-1:0]   r_coef [NC];
    logic signed [BITWIDTH-1:0]   r_xh   [CH][N];
    logic signed [BITWIDTH-1:0]   r_yh   [CH][N];

    logic                         w_ch_ok;
    logic signed [BITWIDTH-1:0]   w_coef;
    logic signed [BITWIDTH-1:0]   w_opnd;
    logic signed [PW-1:0]         w_ce;
    logic signed [PW-1:0]         w_oe;
    logic signed [PW-1:0]         w_prod;
    logic signed [ACC_W-1:0]      w_term;
    logic signed [ACC_W-1:0]      w_sum;
    logic signed [ACC_W-1:0]      w_shf;
    logic                         w_hi;
    logic                         w_lo;
    logic signed [BITWIDTH-1:0]   w_ysat;

    assign in_ready = (r_state == S_IDLE) & ~rst;
    assign busy     = (r_state != S_IDLE);
    assign w_ch_ok  = ({1'b0, in_ch} < c_ch);

    // Step k of the MAC: k=0 current x, 1..N x history, N+1..2N y history.
    always_comb begin
        w_coef = r_coef[0];
        w_opnd = r_x;
        for (int k = 1; k < NC; k++) begin
            if (r_cnt == AW'(k)) w_coef = r_coef[k];
        end
        for (int k = 1; k <= N; k++) begin
            if (r_cnt == AW'(k))     w_opnd = r_xh[r_ch][k-1];
            if (r_cnt == AW'(N + k)) w_opnd = r_yh[r_ch][k-1];
        end
    end

    assign w_ce   = {{BITWIDTH{w_coef[BITWIDTH-1]}}, w_coef};
    assign w_oe   = {{BITWIDTH{w_opnd[BITWIDTH-1]}}, w_opnd};
    assign w_prod = w_ce * w_oe;
    assign w_term = {{AW{w_prod[PW-1]}}, w_prod};

    assign w_sum  = r_acc + c_half;
    assign w_shf  = w_sum >>> FAC;
    assign w_hi   = (w_shf > c_ymax);
    assign w_lo   = (w_shf < c_ymin);
    assign w_ysat = w_hi ? c_ymax[BITWIDTH-1:0] :
                    w_lo ? c_ymin[BITWIDTH-1:0] : w_shf[BITWIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_x       <= '0;
            r_ch      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            y         <= '0;
            out_sat   <= 1'b0;
            err_ch    <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < N; k++) begin
                    r_xh[c][k] <= '0;
                    r_yh[c][k] <= '0;
                end
            end
            for (int k = 0; k < NC; k++) r_coef[k] <= '0;
            r_coef[0] <= c_one;
        end else begin
            err_ch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (coef_we) begin
                        for (int k = 0; k < NC; k++) begin
                            if (coef_addr == AW'(k)) r_coef[k] <= coef_data;
                        end
                    end
                    if (in_valid) begin
                        r_x  <= x;
                        r_ch <= in_ch;
                        if (w_ch_ok) begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_MAC;
                        end else begin
                            err_ch <= 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= (r_cnt <= c_last_b) ? r_acc + w_term : r_acc - w_term;
                    if (r_cnt == c_last) r_state <= S_OUT;
                    else                 r_cnt   <= r_cnt + AW'(1);
                end
                S_OUT: begin
                    y         <= w_ysat;
                    out_sat   <= w_hi | w_lo;
                    out_ch    <= r_ch;
                    out_valid <= 1'b1;
                    // Saturated value feeds back so the recursion stays bounded.
                    for (int k = N-1; k > 0; k--) begin
                        r_xh[r_ch][k] <= r_xh[r_ch][k-1];
                        r_yh[r_ch][k] <= r_yh[r_ch][k-1];
                    end
                    r_xh[r_ch][0] <= r_x;
                    r_yh[r_ch][0] <= w_ysat;
                    r_state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
